yarp_branch_predict_resolve: RTL and testbench

Parametrised branch unit for the YARP core: evaluates all six RV32I B-type conditions and owns a direct-mapped table of 2-bit saturating counters (BHT) that fetch reads for a taken/not-taken prediction. Each resolved branch updates the BHT. The unit raises a registered redirect with the correct next PC when the prediction carried down the pipeline was wrong. It sits between fetch (prediction read port) and execute (resolution port), and keeps branch and mispredict statistics counters.

---
 rtl/yarp_pkg.sv | 25 ++
 rtl/yarp_bht.sv | 56 +++++
 rtl/yarp_branch_predict_resolve.sv | 107 ++++++++++
 tb/tb_yarp_branch_predict_resolve.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared YARP types and constants used by the branch unit.
package yarp_pkg;

    // 2-bit saturating predictor counter; bit 1 is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_t;

    // RV32I B-type func3 encodings.
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // func3 values 010 and 011 do not encode a branch.
    function automatic logic is_legal_branch(input logic [2:0] func3);
        return !((func3 == 3'b010) || (func3 == 3'b011));
    endfunction

endpackage

// File: rtl/yarp_bht.sv
// Direct-mapped table of 2-bit saturating counters.
// One combinational read port (fetch) and one write port (execute).
// A read of the entry being written in the same cycle returns the old value.
module yarp_bht
    import yarp_pkg::*;
#(
    parameter int          ENTRIES  = 64,
    parameter logic [1:0]  CTR_INIT = 2'b01,
    localparam int         IDX      = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDX-1:0]  rd_idx,
    output bht_ctr_t        rd_ctr,
    input  logic            upd_en,
    input  logic [IDX-1:0]  upd_idx,
    input  logic            upd_taken
);

    bht_ctr_t ctr_q [ENTRIES];
    bht_ctr_t cur_ctr;
    bht_ctr_t next_ctr;

    assign rd_ctr  = ctr_q[rd_idx];
    assign cur_ctr = ctr_q[upd_idx];

    // Saturating step of the entry being updated.
    always_comb begin
        next_ctr = cur_ctr;
        if (upd_taken) begin
            case (cur_ctr)
                SNT:     next_ctr = WNT;
                WNT:     next_ctr = WT;
                default: next_ctr = ST;
            endcase
        end else begin
            case (cur_ctr)
                ST:      next_ctr = WT;
                WT:      next_ctr = WNT;
                default: next_ctr = SNT;
            endcase
        end
    end

    // Counter array: all entries return to CTR_INIT on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= bht_ctr_t'(CTR_INIT);
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= next_ctr;
        end
    end

endmodule

// File: rtl/yarp_branch_predict_resolve.sv
// YARP branch unit: evaluates B-type conditions, trains the BHT, and raises a
// registered redirect with the correct next PC on a mispredict.
// Handshake: execute presents a resolve with res_valid_i=1 for one cycle; there
// is no ready, the unit accepts one resolve every cycle and never stalls.
module yarp_branch_predict_resolve
    import yarp_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  pred_pc_i,
    output logic             pred_taken_o,
    input  logic             res_valid_i,
    input  logic             is_b_type_ctl_i,
    input  logic [2:0]       instr_func3_ctl_i,
    input  logic [XLEN-1:0]  res_pc_i,
    input  logic [XLEN-1:0]  opr_a_i,
    input  logic [XLEN-1:0]  opr_b_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    output logic             branch_taken_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [31:0]      br_count_o,
    output logic [31:0]      mispred_count_o
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic            resolve;
    logic            legal;
    logic            cond;
    logic            taken;
    logic            mispred;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] fall_pc;
    bht_ctr_t        rd_ctr;
    logic            unused_pred_bits;

    assign unused_pred_bits = ^{pred_pc_i[XLEN-1:IDX+2], pred_pc_i[1:0]};

    assign resolve   = res_valid_i & is_b_type_ctl_i;
    assign legal     = is_legal_branch(instr_func3_ctl_i);
    assign taken     = resolve & legal & cond;
    assign mispred   = resolve & (taken != pred_taken_i);
    assign target_pc = res_pc_i + imm_i;
    assign fall_pc   = res_pc_i + {{(XLEN-3){1'b0}}, 3'd4};

    // Branch condition from func3; illegal encodings evaluate as not taken.
    always_comb begin
        cond = 1'b0;
        case (instr_func3_ctl_i)
            BEQ:     cond = (opr_a_i == opr_b_i);
            BNE:     cond = (opr_a_i != opr_b_i);
            BLT:     cond = ($signed(opr_a_i) <  $signed(opr_b_i));
            BGE:     cond = ($signed(opr_a_i) >= $signed(opr_b_i));
            BLTU:    cond = (opr_a_i <  opr_b_i);
            BGEU:    cond = (opr_a_i >= opr_b_i);
            default: cond = 1'b0;
        endcase
    end

    yarp_bht #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_INIT (CTR_INIT)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pred_pc_i[IDX+1:2]),
        .rd_ctr    (rd_ctr),
        .upd_en    (resolve & legal),
        .upd_idx   (res_pc_i[IDX+1:2]),
        .upd_taken (cond)
    );

    assign pred_taken_o = (rd_ctr == WT) || (rd_ctr == ST);

    // Resolution outputs: reloaded every cycle so idle cycles read back as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_taken_o <= 1'b0;
            redirect_o     <= 1'b0;
            redirect_pc_o  <= '0;
        end else begin
            branch_taken_o <= taken;
            redirect_o     <= mispred;
            redirect_pc_o  <= mispred ? (taken ? target_pc : fall_pc) : '0;
        end
    end

    // Statistics counters, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count_o      <= '0;
            mispred_count_o <= '0;
        end else begin
            if (resolve && legal && (br_count_o != 32'hFFFF_FFFF))
                br_count_o <= br_count_o + 32'd1;
            if (mispred && (mispred_count_o != 32'hFFFF_FFFF))
                mispred_count_o <= mispred_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_yarp_branch_predict_resolve.sv
// Self-checking bench for yarp_branch_predict_resolve with a behavioural model.
module tb_yarp_branch_predict_resolve;

    localparam int N = 64;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pred_pc_i;
    logic        pred_taken_o;
    logic        res_valid_i;
    logic        is_b_type_ctl_i;
    logic [2:0]  instr_func3_ctl_i;
    logic [31:0] res_pc_i;
    logic [31:0] opr_a_i;
    logic [31:0] opr_b_i;
    logic [31:0] imm_i;
    logic        pred_taken_i;
    logic        branch_taken_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] br_count_o;
    logic [31:0] mispred_count_o;

    always #5 clk = ~clk;

    yarp_branch_predict_resolve dut (
        .clk               (clk),
        .reset             (reset),
        .pred_pc_i         (pred_pc_i),
        .pred_taken_o      (pred_taken_o),
        .res_valid_i       (res_valid_i),
        .is_b_type_ctl_i   (is_b_type_ctl_i),
        .instr_func3_ctl_i (instr_func3_ctl_i),
        .res_pc_i          (res_pc_i),
        .opr_a_i           (opr_a_i),
        .opr_b_i           (opr_b_i),
        .imm_i             (imm_i),
        .pred_taken_i      (pred_taken_i),
        .branch_taken_o    (branch_taken_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .br_count_o        (br_count_o),
        .mispred_count_o   (mispred_count_o)
    );

    // ---------------- reference model ----------------
    int          total = 0;
    int          bad   = 0;
    int          m_ctr [N];
    longint      m_br;
    longint      m_mis;
    logic        exp_taken;
    logic        exp_redir;
    logic [31:0] exp_pc;

    function automatic longint as_signed(input logic [31:0] v);
        return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
    endfunction

    // Returns -1 for an illegal func3, otherwise 0/1 for the branch outcome.
    function automatic int branch_outcome(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (f3)
            3'd0:    return int'(ua == ub);
            3'd1:    return int'(ua != ub);
            3'd4:    return int'(as_signed(a) <  as_signed(b));
            3'd5:    return int'(as_signed(a) >= as_signed(b));
            3'd6:    return int'(ua <  ub);
            3'd7:    return int'(ua >= ub);
            default: return -1;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        return m_ctr[idx_of(pc)] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = 1;
        m_br  = 0;
        m_mis = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        res_valid_i       = 1'b0;
        is_b_type_ctl_i   = 1'b0;
        instr_func3_ctl_i = 3'd0;
        res_pc_i          = '0;
        opr_a_i           = '0;
        opr_b_i           = '0;
        imm_i             = '0;
        pred_taken_i      = 1'b0;
    endtask

    // Presents one resolve at the negedge, advances through the posedge and
    // updates the model; returns 1 ns after the edge with exp_* filled in.
    task automatic drive_resolve(input logic v, input logic bt, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input logic pred);
        int o;
        int k;
        @(negedge clk);
        res_valid_i       = v;
        is_b_type_ctl_i   = bt;
        instr_func3_ctl_i = f3;
        res_pc_i          = pc;
        opr_a_i           = a;
        opr_b_i           = b;
        imm_i             = imm;
        pred_taken_i      = pred;
        o = branch_outcome(f3, a, b);
        exp_taken = v && bt && (o == 1);
        exp_redir = v && bt && (exp_taken != pred);
        exp_pc    = exp_taken ? pc + imm : pc + 32'd4;
        if (v && bt && o >= 0) begin
            k = idx_of(pc);
            if (o == 1) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
            else        m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
            m_br++;
        end
        if (exp_redir) m_mis++;
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        pred_pc_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        model_reset();
        for (int i = 0; i < 4; i++) begin
            pred_pc_i = $urandom;
            #2;
            total++;
            if (pred_taken_o !== 1'b0) begin
                bad++; $display("FAIL reset_pred pc=%h got=%b exp=0", pred_pc_i, pred_taken_o);
            end
        end
        total++;
        if ({branch_taken_o, redirect_o, redirect_pc_o, br_count_o, mispred_count_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got taken=%b redir=%b pc=%h br=%0d mis=%0d exp all 0",
                     branch_taken_o, redirect_o, redirect_pc_o, br_count_o, mispred_count_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_beq();
        drive_resolve(1, 1, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
        total++;
        if (branch_taken_o !== 1'b1 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h120) begin
            bad++;
            $display("FAIL beq got taken=%b redir=%b pc=%h exp 1 1 00000120",
                     branch_taken_o, redirect_o, redirect_pc_o);
        end
        total++;
        if (mispred_count_o !== 32'd1 || br_count_o !== 32'd1) begin
            bad++; $display("FAIL beq_counts got br=%0d mis=%0d exp 1 1", br_count_o, mispred_count_o);
        end
        pred_pc_i = 32'h100;
        #1;
        total++;
        if (pred_taken_o !== 1'b1) begin
            bad++; $display("FAIL beq_bht got pred=%b exp=1", pred_taken_o);
        end
    endtask

    task automatic test_conditions();
        drive_resolve(1, 1, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        total++;
        if (branch_taken_o !== 1'b1 || redirect_o !== 1'b0) begin
            bad++; $display("FAIL blt got taken=%b redir=%b exp 1 0", branch_taken_o, redirect_o);
        end
        drive_resolve(1, 1, 3'd6, 32'h304, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        total++;
        if (branch_taken_o !== 1'b0 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h308) begin
            bad++; $display("FAIL bltu got taken=%b redir=%b pc=%h exp 0 1 00000308",
                            branch_taken_o, redirect_o, redirect_pc_o);
        end
        drive_resolve(1, 1, 3'd7, 32'h308, 32'h8000_0000, 32'd1, 32'h10, 1'b0);
        total++;
        if (branch_taken_o !== 1'b1 || redirect_pc_o !== 32'h318) begin
            bad++; $display("FAIL bgeu got taken=%b pc=%h exp 1 00000318", branch_taken_o, redirect_pc_o);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) drive_resolve(1, 1, 3'd0, 32'h200, 32'd7, 32'd7, 32'h8, 1'b1);
        pred_pc_i = 32'h200;
        #1;
        total++;
        if (pred_taken_o !== 1'b1) begin
            bad++; $display("FAIL sat_high got pred=%b exp=1", pred_taken_o);
        end
        // From 11 a single not-taken must leave a taken prediction (10).
        drive_resolve(1, 1, 3'd1, 32'h200, 32'd7, 32'd7, 32'h8, 1'b1);
        pred_pc_i = 32'h200;
        #1;
        total++;
        if (pred_taken_o !== model_pred(32'h200)) begin
            bad++; $display("FAIL sat_no_overflow got pred=%b exp=%b", pred_taken_o, model_pred(32'h200));
        end
        for (int i = 0; i < 4; i++) drive_resolve(1, 1, 3'd1, 32'h200, 32'd7, 32'd7, 32'h8, 1'b0);
        // Counter now 00; one taken gives 01 (not taken), a second gives 10.
        drive_resolve(1, 1, 3'd0, 32'h200, 32'd1, 32'd1, 32'h8, 1'b0);
        pred_pc_i = 32'h200;
        #1;
        total++;
        if (pred_taken_o !== 1'b0) begin
            bad++; $display("FAIL sat_low_step1 got pred=%b exp=0", pred_taken_o);
        end
        drive_resolve(1, 1, 3'd0, 32'h200, 32'd1, 32'd1, 32'h8, 1'b0);
        pred_pc_i = 32'h200;
        #1;
        total++;
        if (pred_taken_o !== 1'b1) begin
            bad++; $display("FAIL sat_low_step2 got pred=%b exp=1", pred_taken_o);
        end
    endtask

    task automatic test_back_to_back();
        // Index 0x10 is untouched (01): two taken -> 11, then one not-taken -> 10.
        drive_resolve(1, 1, 3'd5, 32'h40, 32'd3, 32'd2, 32'h4, 1'b0);
        drive_resolve(1, 1, 3'd5, 32'h40, 32'd3, 32'd2, 32'h4, 1'b1);
        drive_resolve(1, 1, 3'd4, 32'h40, 32'd3, 32'd2, 32'h4, 1'b1);
        total++;
        if (branch_taken_o !== 1'b0 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h44) begin
            bad++; $display("FAIL b2b_out got taken=%b redir=%b pc=%h exp 0 1 00000044",
                            branch_taken_o, redirect_o, redirect_pc_o);
        end
        pred_pc_i = 32'h40;
        #1;
        total++;
        if (pred_taken_o !== 1'b1) begin
            bad++; $display("FAIL b2b_accumulate got pred=%b exp=1", pred_taken_o);
        end
    endtask

    task automatic test_wrap();
        drive_resolve(1, 1, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b0);
        total++;
        if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h4) begin
            bad++; $display("FAIL wrap_taken got redir=%b pc=%h exp 1 00000004", redirect_o, redirect_pc_o);
        end
        drive_resolve(1, 1, 3'd1, 32'hFFFF_FFFC, 32'd9, 32'd9, 32'd8, 1'b1);
        total++;
        if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0) begin
            bad++; $display("FAIL wrap_fall got redir=%b pc=%h exp 1 00000000", redirect_o, redirect_pc_o);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] br_before;
        logic        pred_before;
        br_before   = 32'(m_br);
        pred_before = model_pred(32'h500);
        drive_resolve(1, 1, 3'b010, 32'h500, 32'd1, 32'd1, 32'h40, 1'b1);
        total++;
        if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h504 || branch_taken_o !== 1'b0) begin
            bad++; $display("FAIL illegal_redirect got taken=%b redir=%b pc=%h exp 0 1 00000504",
                            branch_taken_o, redirect_o, redirect_pc_o);
        end
        total++;
        if (br_count_o !== br_before || mispred_count_o !== 32'(m_mis)) begin
            bad++; $display("FAIL illegal_counts got br=%0d mis=%0d exp %0d %0d",
                            br_count_o, mispred_count_o, br_before, m_mis);
        end
        // Repeat with 011 several times: the entry must not move.
        for (int i = 0; i < 3; i++) drive_resolve(1, 1, 3'b011, 32'h500, 32'd1, 32'd1, 32'h40, 1'b0);
        pred_pc_i = 32'h500;
        #1;
        total++;
        if (pred_taken_o !== pred_before) begin
            bad++; $display("FAIL illegal_bht got pred=%b exp=%b", pred_taken_o, pred_before);
        end
    endtask

    task automatic test_idle();
        drive_resolve(1, 1, 3'd0, 32'h600, 32'd1, 32'd1, 32'h40, 1'b0);
        drive_resolve(1, 0, 3'd0, 32'h600, 32'd1, 32'd1, 32'h40, 1'b0);
        total++;
        if (branch_taken_o !== 1'b0 || redirect_o !== 1'b0) begin
            bad++; $display("FAIL idle_not_branch got taken=%b redir=%b exp 0 0", branch_taken_o, redirect_o);
        end
        drive_resolve(0, 1, 3'd0, 32'h600, 32'd1, 32'd1, 32'h40, 1'b1);
        total++;
        if (branch_taken_o !== 1'b0 || redirect_o !== 1'b0 || br_count_o !== 32'(m_br)) begin
            bad++; $display("FAIL idle_invalid got taken=%b redir=%b br=%0d exp 0 0 %0d",
                            branch_taken_o, redirect_o, br_count_o, m_br);
        end
    endtask

    task automatic test_collision();
        // Index 0x20 (pc 0x80) is still 01; a taken resolve makes it 10.
        @(negedge clk);
        pred_pc_i = 32'h80;
        #1;
        total++;
        if (pred_taken_o !== 1'b0) begin
            bad++; $display("FAIL collision_pre got pred=%b exp=0", pred_taken_o);
        end
        drive_resolve(1, 1, 3'd0, 32'h80, 32'd2, 32'd2, 32'h10, 1'b0);
        total++;
        if (pred_taken_o !== 1'b1) begin
            bad++; $display("FAIL collision_post got pred=%b exp=1", pred_taken_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic        pv;
        for (int n = 0; n < 300; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
            pc = {$urandom_range(0, 255) == 0 ? 24'hFFFFFF : 24'($urandom_range(0, 15)),
                  6'($urandom), 2'b00};
            pv = model_pred(pc);
            drive_resolve($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                          3'($urandom_range(0, 7)), pc, a, b, $urandom, pv ^ ($urandom_range(0, 3) == 0));
            total++;
            if (branch_taken_o !== exp_taken || redirect_o !== exp_redir ||
                (exp_redir && redirect_pc_o !== exp_pc)) begin
                bad++;
                $display("FAIL rand_out n=%0d got taken=%b redir=%b pc=%h exp %b %b %h",
                         n, branch_taken_o, redirect_o, redirect_pc_o, exp_taken, exp_redir, exp_pc);
            end
            total++;
            if (br_count_o !== 32'(m_br) || mispred_count_o !== 32'(m_mis)) begin
                bad++; $display("FAIL rand_counts n=%0d got br=%0d mis=%0d exp %0d %0d",
                                n, br_count_o, mispred_count_o, m_br, m_mis);
            end
            pred_pc_i = {$urandom_range(0, 15), 6'($urandom), 2'($urandom)};
            #1;
            total++;
            if (pred_taken_o !== model_pred(pred_pc_i)) begin
                bad++; $display("FAIL rand_pred n=%0d pc=%h got=%b exp=%b",
                                n, pred_pc_i, pred_taken_o, model_pred(pred_pc_i));
            end
        end
    endtask

    task automatic test_mid_reset();
        // Train pc 0x700 to taken, then hit reset mid-cycle.
        drive_resolve(1, 1, 3'd0, 32'h700, 32'd1, 32'd1, 32'h4, 1'b0);
        drive_resolve(1, 1, 3'd0, 32'h700, 32'd1, 32'd1, 32'h4, 1'b0);
        @(negedge clk);
        res_valid_i       = 1'b1;
        is_b_type_ctl_i   = 1'b1;
        instr_func3_ctl_i = 3'd0;
        res_pc_i          = 32'h700;
        pred_taken_i      = 1'b0;
        pred_pc_i         = 32'h700;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({branch_taken_o, redirect_o, redirect_pc_o, br_count_o, mispred_count_o, pred_taken_o} !== '0) begin
            bad++;
            $display("FAIL mid_reset got taken=%b redir=%b pc=%h br=%0d mis=%0d pred=%b exp all 0",
                     branch_taken_o, redirect_o, redirect_pc_o, br_count_o, mispred_count_o, pred_taken_o);
        end
        // The resolve stays on the bus across an edge while reset is high.
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #1;
        total++;
        if (br_count_o !== 32'd0 || mispred_count_o !== 32'd0 || pred_taken_o !== 1'b0) begin
            bad++; $display("FAIL reset_discard got br=%0d mis=%0d pred=%b exp 0 0 0",
                            br_count_o, mispred_count_o, pred_taken_o);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset     = 1'b1;
        pred_pc_i = '0;
        drive_idle();
        model_reset();
        test_reset();
        test_beq();
        test_conditions();
        test_saturation();
        test_back_to_back();
        test_wrap();
        test_illegal();
        test_idle();
        test_collision();
        test_random();
        test_mid_reset();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
